// File: rtl/window_gen_kxk_if.sv
// window_gen_kxk_if: pixel-in / window-out bundle for window_gen_kxk.
// The master drives pixels and the frame restart; the slave returns windows.
interface window_gen_kxk_if #(
    parameter int DATA_W = 8,
    parameter int K      = 5,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
);
    logic                       clear;
    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       win_valid;
    logic [K*K*DATA_W-1:0]      win_data;
    logic [$clog2(IMG_H)-1:0]   win_row;
    logic [$clog2(IMG_W)-1:0]   win_col;
    logic                       frame_done;
    modport master (output clear, in_valid, in_data,
                    input  win_valid, win_data, win_row, win_col, frame_done);
    modport slave  (input  clear, in_valid, in_data,
                    output win_valid, win_data, win_row, win_col, frame_done);
endinterface

// File: rtl/window_gen_kxk.sv
// window_gen_kxk: KxK sliding-window generator over a raster pixel stream.
// Define WINGEN_OUT_REG_EN to add one output register stage (2 clk latency).
module window_gen_kxk #(
    parameter int DATA_W = 8,
    parameter int K      = 5,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int STRIDE = 1
) (
    input logic             clk,
    input logic             rst,
    window_gen_kxk_if.slave bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int PW = STRIDE > 1 ? $clog2(STRIDE) : 1;
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(STRIDE - 1);

    logic [XW-1:0]         x_q, x_d, col_q, col_d, ocol_q;
    logic [YW-1:0]         y_q, y_d, row_q, row_d, orow_q;
    logic [PW-1:0]         px_q, px_d, py_q, py_d;
    logic [DATA_W-1:0]     line_q [K-1][IMG_W];
    logic [DATA_W-1:0]     win_q  [K][K];
    logic [DATA_W-1:0]     win_d  [K][K];
    logic [DATA_W-1:0]     col_w  [K];
    logic [K*K*DATA_W-1:0] win_flat, data_q;
    logic                  vld_q, done_q;
    logic                  x_end, y_end, x_ok, y_ok, hit;

    // Phase counters replace the modulo; col_q/row_q hold the next window index.
    always_comb begin
        x_end = x_q == X_LAST;
        y_end = y_q == Y_LAST;
        x_ok  = x_q >= X_FIRST;
        y_ok  = y_q >= Y_FIRST;
        hit   = x_ok && y_ok && px_q == '0 && py_q == '0;
        x_d   = x_end ? '0 : x_q + 1'b1;
        y_d   = !x_end ? y_q : y_end ? '0 : y_q + 1'b1;
        px_d  = (x_end || !x_ok || px_q == P_LAST) ? '0 : px_q + 1'b1;
        py_d  = !x_end ? py_q : (y_end || !y_ok || py_q == P_LAST) ? '0 : py_q + 1'b1;
        col_d = x_end ? '0 : hit ? col_q + 1'b1 : col_q;
        row_d = !x_end ? row_q : y_end ? '0 : (y_ok && py_q == '0) ? row_q + 1'b1 : row_q;
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        if (r == K - 1) begin : g_in
            assign col_w[r] = bus.in_data;
        end else begin : g_line
            assign col_w[r] = line_q[K-2-r][x_q];
        end
        for (genvar c = 0; c < K; c++) begin : g_col
            if (c == K - 1) begin : g_new
                assign win_d[r][c] = col_w[r];
            end else begin : g_shift
                assign win_d[r][c] = win_q[r][c+1];
            end
            assign win_flat[(r*K+c)*DATA_W +: DATA_W] = win_d[r][c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {x_q, y_q, px_q, py_q, col_q, row_q} <= '0;
            {vld_q, done_q, orow_q, ocol_q, data_q} <= '0;
            for (int i = 0; i < K - 1; i++)
                for (int j = 0; j < IMG_W; j++)
                    line_q[i][j] <= '0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    win_q[i][j] <= '0;
        end else if (bus.clear) begin
            {x_q, y_q, px_q, py_q, col_q, row_q} <= '0;
            {vld_q, done_q, orow_q, ocol_q, data_q} <= '0;
        end else begin
            vld_q  <= bus.in_valid && hit;
            done_q <= bus.in_valid && x_end && y_end;
            if (bus.in_valid) begin
                {x_q, y_q, px_q, py_q, col_q, row_q} <= {x_d, y_d, px_d, py_d, col_d, row_d};
                line_q[0][x_q] <= bus.in_data;
                for (int i = 1; i < K - 1; i++)
                    line_q[i][x_q] <= line_q[i-1][x_q];
                win_q <= win_d;
                // Output data only moves on a real window so it stays stable otherwise.
                if (hit) {data_q, orow_q, ocol_q} <= {win_flat, row_q, col_q};
            end
        end
    end

`ifdef WINGEN_OUT_REG_EN
    logic                  vld2_q, done2_q;
    logic [YW-1:0]         orow2_q;
    logic [XW-1:0]         ocol2_q;
    logic [K*K*DATA_W-1:0] data2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            {vld2_q, done2_q, orow2_q, ocol2_q, data2_q} <= '0;
        else if (bus.clear)
            {vld2_q, done2_q, orow2_q, ocol2_q, data2_q} <= '0;
        else
            {vld2_q, done2_q, orow2_q, ocol2_q, data2_q} <= {vld_q, done_q, orow_q, ocol_q, data_q};
    end
    assign bus.win_valid  = vld2_q;
    assign bus.frame_done = done2_q;
    assign bus.win_row    = orow2_q;
    assign bus.win_col    = ocol2_q;
    assign bus.win_data   = data2_q;
`else
    assign bus.win_valid  = vld_q;
    assign bus.frame_done = done_q;
    assign bus.win_row    = orow_q;
    assign bus.win_col    = ocol_q;
    assign bus.win_data   = data_q;
`endif
endmodule

// File: tb/tb_window_gen_kxk.sv
// tb_window_gen_kxk: scoreboard bench running STRIDE=1 and STRIDE=2 instances on one stream.
// Expected windows come from a frame-image model using the window rules directly.
module tb_window_gen_kxk;
    localparam int K = 3;
    localparam int W = 8;
    localparam int H = 6;
`ifdef WINGEN_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [71:0] data;
        int          row;
        int          col;
        int          stamp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       clear;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         nw1, nw2, nd1, nd2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nexp(input int s);
        return ((H - K) / s + 1) * ((W - K) / s + 1);
    endfunction

    for (genvar s = 1; s <= 2; s++) begin : g_dut
        window_gen_kxk_if #(.DATA_W(8), .K(K), .IMG_W(W), .IMG_H(H)) ifc ();
        assign ifc.in_valid = in_valid;
        assign ifc.in_data  = in_data;
        assign ifc.clear    = clear;
        window_gen_kxk #(.DATA_W(8), .K(K), .IMG_W(W), .IMG_H(H), .STRIDE(s)) dut (
            .clk(clk),
            .rst(rst),
            .bus(ifc)
        );

        exp_t wq[$];
        int   dq[$];
        int   img[H][W];
        int   mx, my, nwin, ndone;
        exp_t m, e;

        initial begin
            mx = 0; my = 0; nwin = 0; ndone = 0;
        end

        always @(posedge clk or posedge rst) begin
            if (rst || clear) begin
                mx = 0; my = 0;
                wq.delete(); dq.delete();
            end else if (in_valid) begin
                img[my][mx] = int'(in_data);
                if (my >= K - 1 && mx >= K - 1 && (my - K + 1) % s == 0 && (mx - K + 1) % s == 0) begin
                    m.data = '0;
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            m.data[(r*K+c)*8 +: 8] = 8'(img[my-K+1+r][mx-K+1+c]);
                    m.row = (my - K + 1) / s;
                    m.col = (mx - K + 1) / s;
                    m.stamp = cyc + LAT;
                    wq.push_back(m);
                end
                if (mx == W - 1 && my == H - 1) dq.push_back(cyc + LAT);
                mx++;
                if (mx == W) begin
                    mx = 0;
                    my = (my == H - 1) ? 0 : my + 1;
                end
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                if (ifc.win_valid) begin
                    nwin++;
                    check($sformatf("s%0d_win_expected", s), 72'(wq.size() != 0), 72'd1);
                    if (wq.size() != 0) begin
                        e = wq.pop_front();
                        check($sformatf("s%0d_win_data", s), ifc.win_data, e.data);
                        check($sformatf("s%0d_win_row", s), 72'(ifc.win_row), 72'(e.row));
                        check($sformatf("s%0d_win_col", s), 72'(ifc.win_col), 72'(e.col));
                        check($sformatf("s%0d_win_cycle", s), 72'(cyc), 72'(e.stamp));
                    end
                end
                if (ifc.frame_done) begin
                    ndone++;
                    check($sformatf("s%0d_done_expected", s), 72'(dq.size() != 0), 72'd1);
                    if (dq.size() != 0)
                        check($sformatf("s%0d_done_cycle", s), 72'(cyc), 72'(dq.pop_front()));
                end
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic clr);
        in_valid = v;
        in_data  = d;
        clear    = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic mark();
        nw1 = g_dut[1].nwin; nw2 = g_dut[2].nwin;
        nd1 = g_dut[1].ndone; nd2 = g_dut[2].ndone;
    endtask

    task automatic counts(input string nm, input int nf);
        check({nm, "_nwin_s1"}, 72'(g_dut[1].nwin - nw1), 72'(nf * nexp(1)));
        check({nm, "_nwin_s2"}, 72'(g_dut[2].nwin - nw2), 72'(nf * nexp(2)));
        check({nm, "_ndone_s1"}, 72'(g_dut[1].ndone - nd1), 72'(nf));
        check({nm, "_ndone_s2"}, 72'(g_dut[2].ndone - nd2), 72'(nf));
    endtask

    task automatic chk_zero(input string nm);
        check({nm, "_valid"}, 72'({g_dut[1].ifc.win_valid, g_dut[2].ifc.win_valid}), 72'd0);
        check({nm, "_done"}, 72'({g_dut[1].ifc.frame_done, g_dut[2].ifc.frame_done}), 72'd0);
        check({nm, "_data_s1"}, g_dut[1].ifc.win_data, 72'd0);
        check({nm, "_data_s2"}, g_dut[2].ifc.win_data, 72'd0);
        check({nm, "_coords"}, 72'({g_dut[1].ifc.win_row, g_dut[1].ifc.win_col,
                                    g_dut[2].ifc.win_row, g_dut[2].ifc.win_col}), 72'd0);
    endtask

    // mode 0: continuous, 1: valid alternating with idle, 2: random gaps and random data
    task automatic frame(input int mode, input int base, input bit first_chk);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (mode == 2)
                    while ($urandom_range(3) == 0) step(1'b0, 8'($urandom), 1'b0);
                step(1'b1, mode == 2 ? 8'($urandom) : 8'(base + y * 16 + x), 1'b0);
                if (first_chk && y == K - 1 && x == K - 1) begin
                    in_valid = 1'b0;
                    repeat (LAT - 1) begin
                        @(posedge clk);
                        #2;
                    end
                    check("first_valid", 72'(g_dut[1].ifc.win_valid), 72'd1);
                    check("first_data", g_dut[1].ifc.win_data,
                          {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00});
                    check("first_coords", 72'({g_dut[1].ifc.win_row, g_dut[1].ifc.win_col}), 72'd0);
                end
                if (mode == 1) step(1'b0, 8'($urandom), 1'b0);
            end
    endtask

    task automatic part(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 8'((i / W) * 16 + i % W), 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_zero("por");
        rst = 1'b0;
        @(posedge clk);
        #2;
        mark(); frame(0, 0, 1'b1); idle(4); counts("cont", 1);
        mark(); frame(1, 0, 1'b0); idle(4); counts("gappy", 1);
        mark(); frame(0, 0, 1'b0); frame(0, 128, 1'b0); idle(4); counts("b2b", 2);
        part(3 * W + 5);
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_zero("rst_hold");
        rst = 1'b0;
        @(posedge clk);
        #2;
        mark(); frame(0, 0, 1'b0); idle(4); counts("after_rst", 1);
        part(3 * W + 5);
        step(1'b1, 8'hFF, 1'b1);
        chk_zero("clear");
        mark(); frame(0, 0, 1'b0); idle(4); counts("after_clear", 1);
        mark(); repeat (3) frame(2, 0, 1'b0); idle(4); counts("random", 3);
        check("left_win_s1", 72'(g_dut[1].wq.size()), 72'd0);
        check("left_win_s2", 72'(g_dut[2].wq.size()), 72'd0);
        check("left_done", 72'(g_dut[1].dq.size() + g_dut[2].dq.size()), 72'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
